// File: rtl/scan_sequencer_param.sv
// Channel-scan sequencer: walks enabled channels, dwelling SLOT_TICKS ticks on each,
// and emits registered load / slot_last / frame_done strobes.
//
// state | meaning
// IDLE  | waiting for a run request; ticks ignored
// RUN   | counting ticks in the current slot, advancing through enabled channels
// DRAIN | continuous run request dropped; finish current slot, then go idle
module scan_sequencer_param #(
  parameter int N_CH       = 6,
  parameter int AW         = 3,
  parameter int SLOT_TICKS = 12,
  parameter int CW         = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick_a,
  input  logic            tick_b,
  input  logic            enable,
  input  logic            single_shot,
  input  logic            start,
  input  logic [N_CH-1:0] ch_en,
  output logic [AW-1:0]   ch_addr,
  output logic            load,
  output logic            slot_last,
  output logic            frame_done,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] slot_cnt_q, slot_cnt_d;
  logic [AW-1:0] ch_addr_q, ch_addr_d;
  logic          mode_q, mode_d;
  logic          load_q, load_d;
  logic          slot_last_q, slot_last_d;
  logic          frame_done_q, frame_done_d;
  logic          busy_q, busy_d;

  logic          tick, go, draining, slot_end;
  logic [AW-1:0] low_ch, next_ch;
  logic          low_ok, next_ok;

  assign tick     = tick_a | tick_b;
  assign go       = (single_shot ? start : enable) && low_ok;
  // mode_q is the mode latched for the frame in progress; only continuous frames drain
  assign draining = !mode_q && !enable;
  assign slot_end = tick && (slot_cnt_q == CW'(SLOT_TICKS - 1));

  // Lowest enabled channel and next enabled channel above the current one
  always_comb begin
    low_ch  = '0;
    low_ok  = 1'b0;
    next_ch = '0;
    next_ok = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_en[i]) begin
        low_ch = AW'(i);
        low_ok = 1'b1;
        if (i > int'(ch_addr_q)) begin
          next_ch = AW'(i);
          next_ok = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (go) state_d = RUN;
      RUN, DRAIN: begin
        state_d = draining ? DRAIN : RUN;
        if (slot_end) begin
          if (draining)                          state_d = IDLE;
          else if (!next_ok && (mode_q || !low_ok)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    slot_cnt_d   = slot_cnt_q;
    ch_addr_d    = ch_addr_q;
    mode_d       = mode_q;
    load_d       = 1'b0;
    slot_last_d  = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (go) begin
          ch_addr_d  = low_ch;
          slot_cnt_d = '0;
          mode_d     = single_shot;
        end
      end
      RUN, DRAIN: begin
        if (tick) begin
          load_d = (slot_cnt_q == '0);
          if (slot_end) begin
            slot_cnt_d  = '0;
            slot_last_d = 1'b1;
            if (draining) begin
              frame_done_d = !next_ok;
            end else if (next_ok) begin
              ch_addr_d = next_ch;
            end else begin
              frame_done_d = 1'b1;
              // a new continuous frame picks up any pending mode change
              if (!mode_q && low_ok) begin
                ch_addr_d = low_ch;
                mode_d    = single_shot;
              end
            end
          end else begin
            slot_cnt_d = slot_cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q   <= '0;
      ch_addr_q    <= '0;
      mode_q       <= 1'b0;
      load_q       <= 1'b0;
      slot_last_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      ch_addr_q    <= ch_addr_d;
      mode_q       <= mode_d;
      load_q       <= load_d;
      slot_last_q  <= slot_last_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign ch_addr    = ch_addr_q;
  assign load       = load_q;
  assign slot_last  = slot_last_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_scan_sequencer_param.sv
// Directed bench for scan_sequencer_param: continuous/single-shot scans, dual ticks,
// drain, mask clearing and asynchronous reset.
module tb_scan_sequencer_param;
  localparam int N_CH = 6;
  localparam int AW   = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            tick_a = 1'b0;
  logic            tick_b = 1'b0;
  logic            enable = 1'b0;
  logic            single_shot = 1'b0;
  logic            start = 1'b0;
  logic [N_CH-1:0] ch_en = 6'b111111;
  logic [AW-1:0]   ch_addr;
  logic            load, slot_last, frame_done, busy;

  int n_eval = 0;
  int n_fail = 0;
  int n_load, n_last, n_fd, fd_idx, bad;
  logic [AW-1:0] addr_log [1:128];
  logic [AW-1:0] exp_addr;

  always #5 clk = ~clk;

  scan_sequencer_param #(.N_CH(6), .AW(3), .SLOT_TICKS(12), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .tick_a(tick_a), .tick_b(tick_b),
    .enable(enable), .single_shot(single_shot), .start(start), .ch_en(ch_en),
    .ch_addr(ch_addr), .load(load), .slot_last(slot_last),
    .frame_done(frame_done), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive tick inputs at the falling edge, return 1 time unit after the rising edge
  task automatic cyc(input logic ta, input logic tb);
    @(negedge clk);
    tick_a = ta;
    tick_b = tb;
    @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n, input logic both);
    n_load = 0; n_last = 0; n_fd = 0; fd_idx = 0;
    for (int j = 1; j <= n; j++) begin
      cyc(both || (j % 2 == 1), both || (j % 2 == 0));
      if (load) n_load++;
      if (slot_last) n_last++;
      if (frame_done) begin n_fd++; fd_idx = j; end
      if (j <= 128) addr_log[j] = ch_addr;
    end
    tick_a = 1'b0;
    tick_b = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {ch_addr, load, slot_last, frame_done, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0);
    check("idle_busy", busy, 0);

    // 1: continuous full scan of six channels
    enable = 1'b1;
    cyc(0, 0);
    check("t1_start_busy", busy, 1);
    check("t1_start_addr", ch_addr, 0);
    run_ticks(72, 1'b0);
    bad = 0;
    for (int j = 1; j <= 72; j++) begin
      exp_addr = (j < 12) ? 3'd0 : (j < 24) ? 3'd1 : (j < 36) ? 3'd2 :
                 (j < 48) ? 3'd3 : (j < 60) ? 3'd4 : (j < 72) ? 3'd5 : 3'd0;
      if (addr_log[j] !== exp_addr) bad++;
    end
    check("t1_addr_seq_errors", bad, 0);
    check("t1_loads", n_load, 6);
    check("t1_slot_lasts", n_last, 6);
    check("t1_frame_dones", n_fd, 1);
    check("t1_frame_done_tick", fd_idx, 72);
    check("t1_wrap_addr", ch_addr, 0);

    // 3: tick_a and tick_b together count once
    run_ticks(12, 1'b1);
    check("t3_slot_lasts", n_last, 1);
    check("t3_loads", n_load, 1);
    check("t3_addr", ch_addr, 1);

    // 4: drop enable after tick 5 of channel 3
    run_ticks(24, 1'b0);
    check("t4_at_ch3", ch_addr, 3);
    run_ticks(5, 1'b0);
    enable = 1'b0;
    cyc(0, 0);
    check("t4_drain_busy", busy, 1);
    check("t4_drain_addr", ch_addr, 3);
    run_ticks(7, 1'b0);
    check("t4_slot_last_now", slot_last, 1);
    check("t4_slot_lasts", n_last, 1);
    check("t4_frame_dones", n_fd, 0);
    check("t4_busy", busy, 0);
    check("t4_addr", ch_addr, 3);

    // 5: clear the mask during channel 2
    enable = 1'b1;
    cyc(0, 0);
    check("t5_restart_addr", ch_addr, 0);
    run_ticks(27, 1'b0);
    ch_en = 6'b000000;
    cyc(0, 0);
    check("t5_addr_held", ch_addr, 2);
    check("t5_busy_mid", busy, 1);
    run_ticks(9, 1'b0);
    check("t5_frame_done_now", frame_done, 1);
    check("t5_slot_last_now", slot_last, 1);
    check("t5_frame_dones", n_fd, 1);
    check("t5_busy_end", busy, 0);
    cyc(0, 0);
    check("t5_stay_idle", busy, 0);
    single_shot = 1'b1;
    start = 1'b1;
    cyc(0, 0);
    start = 1'b0;
    cyc(0, 0);
    check("t5_start_no_mask", busy, 0);

    // 2: single-shot sparse mask
    enable = 1'b0;
    ch_en = 6'b100101;
    start = 1'b1;
    cyc(0, 0);
    start = 1'b0;
    check("t2_busy", busy, 1);
    check("t2_start_addr", ch_addr, 0);
    run_ticks(36, 1'b0);
    bad = 0;
    for (int j = 1; j <= 36; j++) begin
      exp_addr = (j < 12) ? 3'd0 : (j < 24) ? 3'd2 : 3'd5;
      if (addr_log[j] !== exp_addr) bad++;
    end
    check("t2_addr_seq_errors", bad, 0);
    check("t2_loads", n_load, 3);
    check("t2_slot_lasts", n_last, 3);
    check("t2_frame_done_tick", fd_idx, 36);
    check("t2_busy_end", busy, 0);
    run_ticks(6, 1'b0);
    check("t2_idle_strobes", n_load + n_last + n_fd, 0);
    check("t2_addr_hold", ch_addr, 5);
    check("t2_idle_busy", busy, 0);

    // 6: asynchronous reset mid-slot on channel 4
    single_shot = 1'b0;
    ch_en = 6'b111111;
    enable = 1'b1;
    cyc(0, 0);
    run_ticks(49, 1'b0);
    check("t6_pre_load", load, 1);
    check("t6_pre_addr", ch_addr, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_clear", {ch_addr, load, slot_last, frame_done, busy}, 0);
    cyc(0, 0);
    cyc(0, 0);
    check("t6_held_clear", {ch_addr, load, slot_last, frame_done, busy}, 0);
    rst_n = 1'b1;
    cyc(0, 0);
    check("t6_restart_busy", busy, 1);
    check("t6_restart_addr", ch_addr, 0);
    run_ticks(1, 1'b0);
    check("t6_first_load", load, 1);
    run_ticks(11, 1'b0);
    check("t6_slot_lasts", n_last, 1);
    check("t6_next_addr", ch_addr, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end
endmodule

// File: doc/scan_sequencer_param.md
Name: scan_sequencer_param

Overview:
Parametrised channel-scan sequencer for the multichannel pulse counter. It steps a channel address through N_CH channels, dwelling SLOT_TICKS timebase ticks on each. It issues a load strobe for the shift register and a frame-done strobe used to clear the counters. This generation adds three things: a configurable channel count and dwell length, a live channel-enable mask that skips disabled channels, and single-shot or continuous scan modes with a clean stop at slot boundaries.

Parameters:
N_CH, 6, number of channels scanned (2..16)
AW, 3, channel address width; 2**AW >= N_CH
SLOT_TICKS, 12, ticks per channel slot (2..2**CW)
CW, 4, slot tick counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick_a  in  1  timebase event, counter overflow
tick_b  in  1  timebase event, RTC overflow
enable  in  1  continuous-mode run request (level)
single_shot  in  1  1 = scan one frame per start pulse; 0 = continuous while enable=1
start  in  1  single-cycle start request (single-shot mode)
ch_en  in  N_CH  per-channel enable mask, bit i = channel i
ch_addr  out  AW  current channel address to the mux
load  out  1  one-cycle strobe: shift-register load for current slot
slot_last  out  1  one-cycle strobe: final tick of current slot
frame_done  out  1  one-cycle strobe: last enabled channel's slot completed
busy  out  1  1 while not IDLE

Behaviour:
- tick = tick_a | tick_b, sampled on the rising edge of clk. Simultaneous tick_a and tick_b count as one tick.
- rst_n low, asynchronous: state=IDLE, slot_cnt=0, ch_addr=0, and load, slot_last, frame_done, busy all 0. This holds mid-scan with no partial strobes. Release is synchronous to the next edge.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - ticks ignored; busy=0.
  - Go to RUN when (single_shot=0 and enable=1) or (single_shot=1 and start=1), and ch_en != 0.
  - On entry: ch_addr = lowest set bit of ch_en, slot_cnt=0.
  - If ch_en == 0, stay in IDLE.
- RUN:
  - Each tick increments slot_cnt.
  - The tick taking slot_cnt 0->1 makes load=1 in the following cycle (registered, 1-cycle pulse).
  - The tick arriving with slot_cnt == SLOT_TICKS-1 makes slot_last=1 next cycle, clears slot_cnt to 0, and advances ch_addr to the next higher enabled channel. ch_en is sampled at that edge.
  - If no higher enabled channel exists, the frame ends: frame_done=1 in the same cycle as slot_last.
    - Continuous mode with enable=1: wrap to the lowest enabled channel.
    - Single-shot mode: go to IDLE, ch_addr holds its last value.
  - ch_en == 0 at an advance: frame_done=1, go to IDLE.
  - In continuous mode, enable falling to 0 mid-slot moves the FSM to DRAIN.
  - start while busy is ignored.
- DRAIN:
  - Counts ticks as RUN does, but at the slot end goes to IDLE instead of advancing.
  - frame_done asserts only if the drained channel is the last enabled channel.
  - enable re-asserted during DRAIN returns to RUN with no state loss.
- Mode change (single_shot toggled) while busy takes effect at the next frame end only.
- Mask changes mid-slot never disturb the current ch_addr. A disabled current channel finishes its slot.
- ch_addr is always < N_CH. Mask bits at or above N_CH do not exist.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. Defaults, ch_en=6'b111111, single_shot=0, enable=1, 72 ticks -> ch_addr sequence 0,1,2,3,4,5 each for 12 ticks, load 6 times, slot_last 6 times, frame_done once at the 72nd tick, then ch_addr=0 again.
2. ch_en=6'b100101, single_shot=1, one start pulse, 36 ticks -> ch_addr 0,2,5, frame_done after tick 36, busy=0, further ticks ignored, ch_addr stays 5.
3. tick_a and tick_b high together for 12 consecutive cycles -> slot_cnt advances by 12 (not 24), exactly one slot_last.
4. Continuous mode, enable dropped after tick 5 of channel 3 -> DRAIN; 7 more ticks -> slot_last, no frame_done, busy=0, ch_addr=3.
5. Continuous mode, ch_en set to 0 during channel 2 -> channel 2 completes its slot, then frame_done=1 and IDLE. start with ch_en=0 -> stays IDLE.
6. rst_n pulsed low mid-slot on channel 4 -> all outputs 0 immediately (asynchronous). After release with enable=1, the scan restarts at channel 0 with slot_cnt=0.
